// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding and width helpers for the PLL lock supervisor
package pll_sup_pkg;
    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT} state_t;
    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > 1 ? $clog2(m) : 1;
    endfunction
    function automatic int retry_width(int r);
        return r > 0 ? $clog2(r + 1) : 1;
    endfunction
endpackage

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: PLL-facing and downstream reset signals of the supervisor
interface pll_lock_supervisor_if #(parameter int RW = 1);
    logic          pll_locked;
    logic          relock_req;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          ready;
    logic          fault;
    logic          lol_sticky;
    logic [RW-1:0] retry_count;
    modport master(input pll_locked, relock_req, output pll_rst, sys_rst_n, ready, fault, lol_sticky, retry_count);
    modport slave(output pll_locked, relock_req, input pll_rst, sys_rst_n, ready, fault, lol_sticky, retry_count);
endinterface

// File: rtl/pll_lock_supervisor_bit_sync2.sv
// bit_sync2: two-flop synchronizer for an asynchronous single-bit flag
module bit_sync2 (
    input  logic refclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            m <= 1'b0;
            q <= 1'b0;
        end else begin
            m <= d;
            q <= m;
        end
    end
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, waits for stable lock, releases system reset
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 7
) (
    input logic refclk,
    input logic rst_n,
    pll_lock_supervisor_if.master bus
);
    localparam int CW = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
    localparam int RW = retry_width(MAX_RETRY);
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] retry, retry_n;
    logic          lol, lol_n;
    logic          sys_rst_n_q;
    logic          locked_s;
    bit_sync2 u_sync (.refclk(refclk), .rst_n(rst_n), .d(bus.pll_locked), .q(locked_s));
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            retry       <= '0;
            lol         <= 1'b0;
            sys_rst_n_q <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            retry       <= retry_n;
            lol         <= lol_n;
            sys_rst_n_q <= state_n == RUN;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        retry_n = retry;
        lol_n   = lol;
        case (state)
            RESET_PLL: if (cnt == CW'(RST_PULSE_CYC - 1)) begin
                state_n = WAIT_LOCK;
                cnt_n   = '0;
            end
            WAIT_LOCK: if (locked_s) begin
                state_n = STABILIZE;
                cnt_n   = '0;
            end else if (cnt == CW'(LOCK_TIMEOUT_CYC - 1)) begin
                cnt_n   = '0;
                state_n = retry == RW'(MAX_RETRY) ? FAULT : RESET_PLL;
                retry_n = retry == RW'(MAX_RETRY) ? retry : retry + 1'b1;
            end
            STABILIZE: if (!locked_s) begin
                state_n = WAIT_LOCK;
                cnt_n   = '0;
            end else if (cnt == CW'(LOCK_STABLE_CYC - 1)) begin
                state_n = RUN;
                cnt_n   = '0;
                retry_n = '0;
            end
            RUN: begin
                cnt_n = '0;
                if (!locked_s) begin
                    state_n = RESET_PLL;
                    lol_n   = 1'b1;
                end
            end
            default: begin
                state_n = FAULT;
                cnt_n   = '0;
            end
        endcase
        if (bus.relock_req) begin
            state_n = RESET_PLL;
            cnt_n   = '0;
            retry_n = '0;
            lol_n   = 1'b0;
        end
    end
    assign bus.pll_rst     = state == RESET_PLL;
    assign bus.ready       = state == RUN;
    assign bus.fault       = state == FAULT;
    assign bus.sys_rst_n   = sys_rst_n_q;
    assign bus.lol_sticky  = lol;
    assign bus.retry_count = retry;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed self-checking bench for the PLL lock supervisor
module tb_pll_lock_supervisor;
    localparam int SEL_PLL_RST = 0;
    localparam int SEL_SYS_RST = 1;
    localparam int SEL_FAULT   = 2;
    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    pll_lock_supervisor_if #(.RW(2)) bus();
    pll_lock_supervisor #(
        .RST_PULSE_CYC(4), .LOCK_TIMEOUT_CYC(20), .LOCK_STABLE_CYC(8), .MAX_RETRY(2)
    ) dut (.refclk(refclk), .rst_n(rst_n), .bus(bus));
    always #10 refclk = ~refclk;
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask
    function automatic logic pick(int w);
        return w == SEL_PLL_RST ? bus.pll_rst : w == SEL_SYS_RST ? bus.sys_rst_n : bus.fault;
    endfunction
    task automatic count_until(input int w, input logic v, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (pick(w) !== v && n < 300);
        if (pick(w) !== v) n = -1;
    endtask
    task automatic test_reset();
        int n;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        rst_n = 1'b0;
        tick(); tick(); tick();
        vectors++;
        if ({bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fault, bus.lol_sticky} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 10000", {bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fault, bus.lol_sticky});
        end
        vectors++;
        if (bus.retry_count !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_retry: got %0d want 0", bus.retry_count);
        end
    endtask
    task automatic nominal_release(input string tag);
        int n;
        rst_n = 1'b1;
        count_until(SEL_PLL_RST, 1'b0, n);
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL %s_pulse: got %0d want 4", tag, n);
        end
        repeat (9) tick();
        bus.pll_locked = 1'b1;
        count_until(SEL_SYS_RST, 1'b1, n);
        vectors++;
        if (n !== 11) begin
            miscompares++;
            $display("FAIL %s_release: got %0d want 11", tag, n);
        end
        vectors++;
        if ({bus.ready, bus.pll_rst, bus.fault, bus.retry_count} !== 5'b10000) begin
            miscompares++;
            $display("FAIL %s_run_state: got %b want 10000", tag, {bus.ready, bus.pll_rst, bus.fault, bus.retry_count});
        end
    endtask
    task automatic test_nominal();
        nominal_release("nominal");
    endtask
    task automatic test_loss_of_lock();
        int n;
        bus.pll_locked = 1'b0;
        count_until(SEL_SYS_RST, 1'b0, n);
        vectors++;
        if (n !== 3) begin
            miscompares++;
            $display("FAIL lol_latency: got %0d want 3", n);
        end
        vectors++;
        if ({bus.ready, bus.lol_sticky, bus.pll_rst} !== 3'b011) begin
            miscompares++;
            $display("FAIL lol_flags: got %b want 011", {bus.ready, bus.lol_sticky, bus.pll_rst});
        end
        count_until(SEL_PLL_RST, 1'b0, n);
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL lol_pulse: got %0d want 4", n);
        end
        bus.pll_locked = 1'b1;
        count_until(SEL_SYS_RST, 1'b1, n);
        vectors++;
        if (n !== 11 || bus.lol_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL lol_relock: got %0d/%b want 11/1", n, bus.lol_sticky);
        end
    endtask
    task automatic test_glitch();
        int  n;
        logic leak;
        bus.pll_locked = 1'b0;
        count_until(SEL_SYS_RST, 1'b0, n);
        count_until(SEL_PLL_RST, 1'b0, n);
        count_until(SEL_PLL_RST, 1'b1, n);
        vectors++;
        if (n !== 20 || bus.retry_count !== 2'd1) begin
            miscompares++;
            $display("FAIL glitch_timeout: got %0d/%0d want 20/1", n, bus.retry_count);
        end
        count_until(SEL_PLL_RST, 1'b0, n);
        bus.pll_locked = 1'b1;
        leak = 1'b0;
        repeat (6) begin
            tick();
            leak |= bus.sys_rst_n;
        end
        bus.pll_locked = 1'b0;
        tick();
        leak |= bus.sys_rst_n;
        bus.pll_locked = 1'b1;
        repeat (3) begin
            tick();
            leak |= bus.sys_rst_n;
        end
        vectors++;
        if (leak !== 1'b0 || bus.retry_count !== 2'd1) begin
            miscompares++;
            $display("FAIL glitch_hold: got leak=%b retry=%0d want leak=0 retry=1", leak, bus.retry_count);
        end
        count_until(SEL_SYS_RST, 1'b1, n);
        vectors++;
        if (n !== 8) begin
            miscompares++;
            $display("FAIL glitch_release: got %0d want 8 (11 from re-rise)", n);
        end
    endtask
    task automatic test_never_lock();
        int   n;
        logic bad;
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            count_until(SEL_PLL_RST, 1'b0, n);
            vectors++;
            if (n !== 4) begin
                miscompares++;
                $display("FAIL never_pulse%0d: got %0d want 4", i, n);
            end
            count_until(i < 2 ? SEL_PLL_RST : SEL_FAULT, 1'b1, n);
            vectors++;
            if (n !== 20 || bus.retry_count !== 2'(i < 2 ? i + 1 : 2)) begin
                miscompares++;
                $display("FAIL never_gap%0d: got %0d/%0d want 20/%0d", i, n, bus.retry_count, i < 2 ? i + 1 : 2);
            end
        end
        bad = 1'b0;
        repeat (100) begin
            tick();
            bad |= {bus.fault, bus.pll_rst, bus.sys_rst_n, bus.ready, bus.retry_count} !== 6'b100010;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL never_fault_hold: got %b want 100010", {bus.fault, bus.pll_rst, bus.sys_rst_n, bus.ready, bus.retry_count});
        end
    endtask
    task automatic test_relock_fault();
        int n;
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        vectors++;
        if ({bus.fault, bus.pll_rst, bus.retry_count} !== 4'b0100) begin
            miscompares++;
            $display("FAIL relock_fault: got %b want 0100", {bus.fault, bus.pll_rst, bus.retry_count});
        end
        count_until(SEL_PLL_RST, 1'b0, n);
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL relock_fault_pulse: got %0d want 4", n);
        end
    endtask
    task automatic test_relock_run();
        int n;
        bus.pll_locked = 1'b1;
        count_until(SEL_SYS_RST, 1'b1, n);
        bus.pll_locked = 1'b0;
        count_until(SEL_SYS_RST, 1'b0, n);
        bus.pll_locked = 1'b1;
        count_until(SEL_SYS_RST, 1'b1, n);
        vectors++;
        if (bus.lol_sticky !== 1'b1 || bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL relock_run_pre: got lol=%b ready=%b want 1/1", bus.lol_sticky, bus.ready);
        end
        bus.pll_locked = 1'b0;
        tick(); tick();
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        vectors++;
        if ({bus.lol_sticky, bus.pll_rst, bus.ready, bus.sys_rst_n} !== 4'b0100) begin
            miscompares++;
            $display("FAIL relock_run: got %b want 0100", {bus.lol_sticky, bus.pll_rst, bus.ready, bus.sys_rst_n});
        end
    endtask
    task automatic test_rst_mid_stabilize();
        int n;
        count_until(SEL_PLL_RST, 1'b0, n);
        bus.pll_locked = 1'b1;
        repeat (5) tick();
        bus.pll_locked = 1'b0;
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fault, bus.lol_sticky, bus.retry_count} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %b want 1000000", {bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fault, bus.lol_sticky, bus.retry_count});
        end
        nominal_release("midrst");
    endtask
    initial begin
        test_reset();
        test_nominal();
        test_loss_of_lock();
        test_glitch();
        test_never_lock();
        test_relock_fault();
        test_relock_run();
        test_rst_mid_stabilize();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
